// File: rtl/mux_4x1_rr.sv
// Four-channel round-robin merge onto one registered valid/ready stream, with the source tag on S1/S0.
// Defining MUX_4X1_RR_FIXED_PRI_EN swaps round-robin for fixed priority (channel 0 highest).
module mux_4x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic             V0,
  input  logic             V1,
  input  logic             V2,
  input  logic             V3,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic [WIDTH-1:0] Out,
  output logic             S1,
  output logic             S0,
  output logic             Out_valid,
  input  logic             Out_ready
);
  localparam int NUM_LANES = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [WIDTH-1:0]                  out_q, out_d;
  logic [1:0]                        src_q, src_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]   d;
  logic [NUM_LANES-1:0]              v, r;
  logic [1:0]                        start, gnt;
  logic                              any, load_en, xfer;

  assign d = {D3, D2, D1, D0};
  assign v = {V3, V2, V1, V0};

`ifdef MUX_4X1_RR_FIXED_PRI_EN
  assign start = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  assign start = ptr_q;
  assign ptr_d = xfer ? gnt + 2'd1 : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  // First requester at or after start, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    any = 1'b0;
    gnt = 2'd0;
    idx = 2'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = start + 2'(k);
      if (!any && v[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  // rst gate keeps every ready low during reset even though the stage reads EMPTY.
  assign load_en = !rst && ((state_q == EMPTY) || Out_ready);
  assign xfer    = load_en && any;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign r[i] = xfer && (gnt == 2'(i));
  end

  assign {R3, R2, R1, R0} = r;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    src_d   = src_q;
    if (xfer) begin
      state_d = FULL;
      out_d   = d[gnt];
      src_d   = gnt;
    end else if (state_q == FULL && Out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      src_q   <= src_d;
    end
  end

  assign Out       = out_q;
  assign {S1, S0}  = src_q;
  assign Out_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux_4x1_rr.sv
// Directed vector table plus a reset-mid-stream sequence for mux_4x1_rr.
module tb_mux_4x1_rr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] D0 = '0, D1 = '0, D2 = '0, D3 = '0;
  logic       V0 = 1'b0, V1 = 1'b0, V2 = 1'b0, V3 = 1'b0;
  logic       R0, R1, R2, R3;
  logic [7:0] Out;
  logic       S1, S0, Out_valid;
  logic       Out_ready = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  mux_4x1_rr #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Out(Out), .S1(S1), .S0(S0),
    .Out_valid(Out_valid), .Out_ready(Out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [7:0] d0, d1, d2, d3;
    logic       ordy;
    logic [3:0] er;
    logic       ev;
    logic [7:0] eo;
    logic [1:0] es;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r_, input logic [3:0] v_, input logic [7:0] a, b, c, e,
                     input logic o_, input logic [3:0] er_, input logic ev_,
                     input logic [7:0] eo_, input logic [1:0] es_);
    vec_t t;
    t.rst = r_; t.v = v_; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = e; t.ordy = o_;
    t.er = er_; t.ev = ev_; t.eo = eo_; t.es = es_;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; {V3, V2, V1, V0} = t.v;
    D0 = t.d0; D1 = t.d1; D2 = t.d2; D3 = t.d3; Out_ready = t.ordy;
  endtask

  initial begin
    int k;
    // reset held with all channels requesting
    add(1, 4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 8'h00, 2'd0);
    // single channel 2
    add(0, 4'b0100, 8'h10, 8'h11, 8'hA5, 8'h13, 1, 4'b0100, 1, 8'hA5, 2'd2);
    // idle drains, data/tag hold
    add(0, 4'b0000, 8'h10, 8'h11, 8'hA5, 8'h13, 1, 4'b0000, 0, 8'hA5, 2'd2);
    // reset restarts pointer at 0
    add(1, 4'b0000, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 8'h00, 2'd0);
    // fairness: 8 cycles all valid
    for (int i = 0; i < 8; i++) begin
`ifdef MUX_4X1_RR_FIXED_PRI_EN
      k = 0;
`else
      k = i % 4;
`endif
      add(0, 4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'(1 << k), 1, 8'(8'h10 + k), 2'(k));
    end
    // backpressure
    add(0, 4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 4'b0010, 1, 8'h3C, 2'd1);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0001, 8'h5A, 8'h3C, 8'h00, 8'h00, 0, 4'b0000, 1, 8'h3C, 2'd1);
    add(0, 4'b0001, 8'h5A, 8'h3C, 8'h00, 8'h00, 1, 4'b0001, 1, 8'h5A, 2'd0);
    // wrap: ch3 then ch0/ch3 -> ch0 first
    add(0, 4'b1000, 8'h5A, 8'h00, 8'h00, 8'h77, 1, 4'b1000, 1, 8'h77, 2'd3);
    add(0, 4'b1001, 8'h5A, 8'h00, 8'h00, 8'h77, 1, 4'b0001, 1, 8'h5A, 2'd0);
    add(0, 4'b1000, 8'h5A, 8'h00, 8'h00, 8'h77, 1, 4'b1000, 1, 8'h77, 2'd3);
    // idle fall, then empty idle with Out_ready low
    add(0, 4'b0000, 8'h5A, 8'h00, 8'h00, 8'h77, 1, 4'b0000, 0, 8'h77, 2'd3);
    add(0, 4'b0000, 8'h5A, 8'h00, 8'h00, 8'h77, 0, 4'b0000, 0, 8'h77, 2'd3);
    // EMPTY loads regardless of Out_ready; leaves ptr at 1, FULL
    add(0, 4'b0001, 8'h5A, 8'h00, 8'h00, 8'h77, 0, 4'b0001, 1, 8'h5A, 2'd0);

    #2;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("R", i, 32'({R3, R2, R1, R0}), 32'(tv[i].er));
      @(posedge clk);
      #1;
      chk("Out_valid", i, 32'(Out_valid), 32'(tv[i].ev));
      chk("Out", i, 32'(Out), 32'(tv[i].eo));
      chk("S", i, 32'({S1, S0}), 32'(tv[i].es));
    end

    // reset mid-stream: stage FULL, Out_ready low, ptr=1
    @(negedge clk);
    {V3, V2, V1, V0} = 4'b0011; D0 = 8'hC0; D1 = 8'hC1; Out_ready = 1'b0;
    #1;
    chk("hold_valid", 100, 32'(Out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_valid", 100, 32'(Out_valid), 32'd0);
    chk("rst_out", 100, 32'(Out), 32'd0);
    chk("rst_R", 100, 32'({R3, R2, R1, R0}), 32'd0);
    @(negedge clk);
    rst = 1'b0; Out_ready = 1'b1;
    #1;
    chk("restart_R", 101, 32'({R3, R2, R1, R0}), 32'b0001);
    @(posedge clk);
    #1;
    chk("restart_out", 101, 32'(Out), 32'hC0);
    chk("restart_S", 101, 32'({S1, S0}), 32'd0);
    chk("restart_valid", 101, 32'(Out_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mux_4x1_rr.md
# mux_4x1_rr

Four-channel round-robin multiplexer: the merging end of the 1:4 demultiplexer path. It accepts data beats from four input channels under valid/ready handshakes and serializes them onto one registered output stream. Each output beat carries the 2-bit source channel number on S1/S0, so a downstream 1:4 demultiplexer can route it back to the matching lane.

## Interface
- WIDTH, 8, data width of every input channel and of Out.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- D0..D3  input  WIDTH each  channel data.
- V0..V3  input  1 each  channel valid.
- R0..R3  output  1 each  channel ready, combinational; at most one is high per cycle.
- Out  output  WIDTH  registered output data.
- S1, S0  output  1 each  registered source channel number of Out (S1 = MSB).
- Out_valid  output  1  output beat valid.
- Out_ready  input  1  downstream accepts the beat.

## Operation
- Input rule: once Vi rises, Vi and Di hold stable until the cycle in which Vi && Ri.
- Output stage: one-entry register with states EMPTY (Out_valid=0) and FULL (Out_valid=1).
- load_en = EMPTY or (FULL && Out_ready).
- Grant: when load_en=1, select the first channel with Vi=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Ri = load_en && (grant==i). All Ri are 0 when load_en=0 or no Vi is high.
- Transfer on channel g at the clock edge:
  - Out <= Dg, {S1,S0} <= g, Out_valid <= 1.
  - ptr <= (g+1) mod 4, with 2-bit wrap, so 3 wraps to 0.
- FULL && Out_ready with no Vi high: Out_valid <= 0, ptr unchanged, Out and S hold their last values.
- FULL && !Out_ready: Out, S and Out_valid hold. All Ri are 0.
- ptr changes only on a transfer.

## Timing
- Reset values (asynchronous, immediate): Out=0, S1=0, S0=0, Out_valid=0, ptr=0. All Ri are 0 while rst is high.
- Latency: a beat accepted at edge N appears with Out_valid=1 immediately after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while Out_ready=1 continuously.
- The Ri→Vi and Out_ready→Ri paths are combinational. Vi must not depend combinationally on Ri.
- All four Vi high with Out_ready=1 gives the grant order 0,1,2,3,0,... with no channel skipped.
- Reset asserted mid-transfer: the pending beat is discarded and Out_valid falls immediately. After release, arbitration restarts at channel 0.

## Configuration
- MUX_4X1_RR_FIXED_PRI_EN not defined:
  - Round-robin arbitration as above.
- MUX_4X1_RR_FIXED_PRI_EN defined:
  - Fixed priority, channel 0 highest and channel 3 lowest.
  - ptr is removed and the search always starts at channel 0.
  - All other handshake and timing behaviour is identical.

## Test plan
- Reset check: hold rst=1 with V0..V3=1111 → Out=0, S=00, Out_valid=0, R0..R3=0000.
- Single channel: V2=1, D2=0xA5, Out_ready=1 → R2=1 that cycle. Next cycle Out=0xA5, {S1,S0}=10, Out_valid=1.
- Round-robin fairness: all Vi=1, Di=0x10+i, Out_ready=1 for 8 cycles → Out sequence 0x10,0x11,0x12,0x13,0x10,0x11,0x12,0x13 with S = 00,01,10,11 repeating.
  - With MUX_4X1_RR_FIXED_PRI_EN defined: Out stays 0x10 every cycle.
- Backpressure: fill with D1=0x3C, then Out_ready=0 for 3 cycles while V0=1 → Out holds 0x3C/S=01 and R0 stays 0. When Out_ready=1, R0=1 that cycle and the next Out is D0.
- Wrap and idle: the only transfer is on ch3, then V0=V3=1 → ch0 is granted first (ptr wrapped 3→0). Then with no Vi and Out_ready=1 → Out_valid falls to 0 next cycle.
- Reset mid-stream: assert rst while Out_valid=1 with Out_ready=0 → Out_valid=0 with no clock edge. After release with V1=V0=1 → ch0 is granted first.
